// File: rtl/spi_receive_scratch.sv
// rtl/spi_receive_scratch.sv - SPI slave receiver: oversampled SCLK/MOSI/CS, MSB-first word capture
module spi_receive_scratch #(
  parameter int DATASIZE    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                i_Clk,
  input  logic                i_Rst_L,
  input  logic                i_Enable,
  input  logic                i_EdgeShape,
  input  logic                i_SCLK,
  input  logic                i_MOSI,
  input  logic                i_CS,
  output logic [DATASIZE-1:0] o_Data,
  output logic                o_Valid,
  output logic                o_Busy,
  output logic                o_FrameErr
);

  localparam int CW = $clog2(DATASIZE + 1);

  typedef enum logic [1:0] {IDLE, RECEIVE, WAIT_CS} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                    sclk_prev_q, sclk_prev_d;
  logic [DATASIZE-1:0]     shreg_q, shreg_d;
  logic [DATASIZE-1:0]     data_q, data_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    done_q, done_d;
  logic                    valid_q, valid_d;
  logic                    ferr_q, ferr_d;
  logic                    cs_s, sclk_s, mosi_s, samp_edge;

  // Synchronisers run regardless of i_Enable so pin state is current when re-enabled.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cs_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_CS};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SCLK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_MOSI};
    end
  end

  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign samp_edge = i_EdgeShape ? (sclk_s & ~sclk_prev_q) : (~sclk_s & sclk_prev_q);

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      shreg_q     <= '0;
      data_q      <= '0;
      count_q     <= '0;
      done_q      <= 1'b0;
      valid_q     <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_prev_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      count_q     <= count_d;
      done_q      <= done_d;
      valid_q     <= valid_d;
      ferr_q      <= ferr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sclk_prev_d = sclk_s;
    shreg_d     = shreg_q;
    data_d      = data_q;
    count_d     = count_q;
    done_d      = 1'b0;
    valid_d     = 1'b0;
    ferr_d      = 1'b0;

    // The completed word is published one cycle after its last bit is shifted in.
    if (done_q) begin
      data_d  = shreg_q;
      valid_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (!cs_s) state_d = RECEIVE;
      end
      RECEIVE: begin
        if (cs_s) begin
          ferr_d  = (count_q != '0);
          count_d = '0;
          state_d = IDLE;
        end else if (samp_edge) begin
          shreg_d = {shreg_q[DATASIZE-2:0], mosi_s};
          count_d = count_q + 1'b1;
          if (count_q == CW'(DATASIZE - 1)) begin
            done_d  = 1'b1;
            state_d = WAIT_CS;
          end
        end
      end
      WAIT_CS: begin
        if (cs_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (!i_Enable) begin
      state_d     = IDLE;
      sclk_prev_d = 1'b0;
      shreg_d     = '0;
      data_d      = '0;
      count_d     = '0;
      done_d      = 1'b0;
      valid_d     = 1'b0;
      ferr_d      = 1'b0;
    end
  end

  assign o_Data     = data_q;
  assign o_Valid    = valid_q;
  assign o_FrameErr = ferr_q;
  assign o_Busy     = (state_q != IDLE);

endmodule

// File: tb/tb_spi_receive_scratch.sv
// tb/tb_spi_receive_scratch.sv - self-checking bench for spi_receive_scratch
module tb_spi_receive_scratch;

  localparam int DW = 16;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst_n, en, shape, sclk, mosi, cs;
  logic [DW-1:0] dut_data;
  logic          dut_valid, dut_busy, dut_ferr;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            lat;
  int            got_ferr = 0;
  int            exp_ferr = 0;
  logic [DW-1:0] got_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] last_data;

  always #5 clk = ~clk;

  spi_receive_scratch #(.DATASIZE(DW), .SYNC_STAGES(SS)) dut (
    .i_Clk(clk), .i_Rst_L(rst_n), .i_Enable(en), .i_EdgeShape(shape),
    .i_SCLK(sclk), .i_MOSI(mosi), .i_CS(cs),
    .o_Data(dut_data), .o_Valid(dut_valid), .o_Busy(dut_busy), .o_FrameErr(dut_ferr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (dut_valid) got_q.push_back(dut_data);
    if (dut_ferr) got_ferr++;
    if (dut_valid || dut_ferr) check("valid_ferr_exclusive", {31'd0, dut_valid & dut_ferr}, 32'd0);
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a CS window with n bits yields the first DW bits as a word if n >= DW,
  // a frame error if 0 < n < DW, and nothing if n == 0.
  task automatic model_frame(input logic [31:0] bits, input int nbits);
    logic [31:0] w;
    if (nbits >= DW) begin
      w = bits >> (nbits - DW);
      exp_q.push_back(w[DW-1:0]);
      last_data = w[DW-1:0];
    end else if (nbits > 0) begin
      exp_ferr++;
    end
  endtask

  task automatic check_sb(input string tag);
    logic [DW-1:0] g, e;
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    check({tag, "_nferr"}, got_ferr, exp_ferr);
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      check({tag, "_word"}, g, e);
    end
    got_q.delete();
    exp_q.delete();
    check({tag, "_data_hold"}, dut_data, last_data);
  endtask

  // Sends nbits of bits (MSB first from bit nbits-1); lat records which negedge sample
  // after the last sampling transition first shows o_Valid.
  task automatic send_frame(input logic shp, input logic [31:0] bits, input int nbits,
                            input bit raise_cs, input int gap);
    logic idle_lvl;
    idle_lvl = ~shp;
    @(negedge clk);
    shape = shp;
    sclk  = idle_lvl;
    wait_clks(4);
    cs = 1'b0;
    wait_clks(4);
    for (int i = nbits - 1; i >= 0; i--) begin
      mosi = bits[i];
      wait_clks(4);
      sclk = ~idle_lvl;
      lat  = 0;
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        if (dut_valid && lat == 0) lat = k;
      end
      sclk = idle_lvl;
    end
    wait_clks(2);
    if (raise_cs) begin
      cs = 1'b1;
      wait_clks(gap);
    end
  endtask

  initial begin
    logic [31:0] w;
    int          nb;
    rst_n = 1'b0; en = 1'b1; shape = 1'b1; sclk = 1'b0; mosi = 1'b0; cs = 1'b1;
    last_data = '0;
    #12;
    check("rst_data", dut_data, 32'd0);
    check("rst_valid", dut_valid, 32'd0);
    check("rst_busy", dut_busy, 32'd0);
    check("rst_ferr", dut_ferr, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    wait_clks(4);

    // Rising-edge sampling, latency and busy-fall timing.
    send_frame(1'b1, 32'hA5C3, 16, 1'b0, 0);
    model_frame(32'hA5C3, 16);
    // Valid registers SS+1 posedges after the first posedge that sees the transition.
    check("t1_latency", lat, SS + 2);
    check("t1_busy_before_cs", dut_busy, 32'd1);
    cs = 1'b1;
    wait_clks(SS);
    check("t1_busy_hold", dut_busy, 32'd1);
    wait_clks(1);
    check("t1_busy_fall", dut_busy, 32'd0);
    wait_clks(3);
    check_sb("t1");

    send_frame(1'b0, 32'h8001, 16, 1'b1, 6);
    model_frame(32'h8001, 16);
    check_sb("t2");

    send_frame(1'b1, 32'h1234, 16, 1'b1, 6);
    model_frame(32'h1234, 16);
    send_frame(1'b1, 32'h55, 7, 1'b1, 6);
    model_frame(32'h55, 7);
    check_sb("t3_partial");
    send_frame(1'b1, 32'hFFFF, 16, 1'b1, 6);
    model_frame(32'hFFFF, 16);
    check_sb("t3_next");

    send_frame(1'b1, 32'h0F0F5, 20, 1'b1, 6);
    model_frame(32'h0F0F5, 20);
    check_sb("t4");

    send_frame(1'b0, 32'hDEAD, 16, 1'b1, 4);
    model_frame(32'hDEAD, 16);
    send_frame(1'b0, 32'hBEEF, 16, 1'b1, 4);
    model_frame(32'hBEEF, 16);
    wait_clks(4);
    check_sb("t5");

    // Asynchronous reset mid-frame.
    send_frame(1'b1, 32'h1FF, 9, 1'b0, 0);
    check("t6_busy_mid", dut_busy, 32'd1);
    @(posedge clk); #3;
    rst_n = 1'b0; cs = 1'b1;
    #1;
    check("t6_rst_data", dut_data, 32'd0);
    check("t6_rst_valid", dut_valid, 32'd0);
    check("t6_rst_busy", dut_busy, 32'd0);
    check("t6_rst_ferr", dut_ferr, 32'd0);
    last_data = '0;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(6);
    check_sb("t6_rst");

    // Synchronous clear through i_Enable mid-frame.
    send_frame(1'b1, 32'h3C5A, 16, 1'b1, 6);
    model_frame(32'h3C5A, 16);
    send_frame(1'b1, 32'h0AB, 9, 1'b0, 0);
    en = 1'b0;
    wait_clks(1);
    check("t6_en_data", dut_data, 32'd0);
    check("t6_en_busy", dut_busy, 32'd0);
    last_data = '0;
    cs = 1'b1;
    wait_clks(6);
    en = 1'b1;
    wait_clks(2);
    check_sb("t6_en");
    w = $urandom_range(0, 16'hFFFF);
    send_frame(1'b1, w, 16, 1'b1, 6);
    model_frame(w, 16);
    check_sb("t6_after");

    // Random words, edge shapes and bit counts.
    for (int r = 0; r < 8; r++) begin
      w  = $urandom();
      nb = $urandom_range(0, 20);
      w  = w & ((32'd1 << nb) - 1);
      send_frame(1'($urandom_range(0, 1)), w, nb, 1'b1, $urandom_range(4, 8));
      model_frame(w, nb);
      check_sb("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
